// File: rtl/calc_pkg.sv
// Shared definitions for the RPN stack calculator sequencer.
//   - token operator codes (TOK_ADD .. TOK_CLR)
//   - sequencer FSM state encoding
//   - error codes reported on err_code
//   - helper to classify arithmetic operators
package calc_pkg;

    localparam logic [3:0] TOK_ADD = 4'hA;
    localparam logic [3:0] TOK_SUB = 4'hB;
    localparam logic [3:0] TOK_MUL = 4'hC;
    localparam logic [3:0] TOK_DIV = 4'hD;
    localparam logic [3:0] TOK_EQU = 4'hE;
    localparam logic [3:0] TOK_CLR = 4'hF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ALU = 3'd1,
        PUSH     = 3'd2,
        DONE     = 3'd3,
        ERROR    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_MALFORMED = 2'd0;
    localparam logic [1:0] ERR_OVF       = 2'd1;
    localparam logic [1:0] ERR_UNF       = 2'd2;
    localparam logic [1:0] ERR_ALU       = 2'd3;

    // Operators that consume two operands and go through the arithmetic unit.
    function automatic logic is_arith_op(input logic [3:0] op);
        return (op >= TOK_ADD) && (op <= TOK_DIV);
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Bundle of the sequencer's token, arithmetic-unit and result signals.
//   master : the environment (token source, arithmetic unit, display path)
//   slave  : the calc_sequencer itself
// Token side : tok_valid/tok_ready handshake, tok_is_num, tok_op, tok_value
// ALU side   : alu_start, alu_op, alu_a, alu_b  ->  alu_done, alu_err, alu_result
// Result side: result_valid, result, error, err_code, depth
interface calc_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic             tok_valid;
    logic             tok_ready;
    logic             tok_is_num;
    logic [3:0]       tok_op;
    logic [WIDTH-1:0] tok_value;

    logic             alu_start;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_done;
    logic             alu_err;
    logic [WIDTH-1:0] alu_result;

    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             error;
    logic [1:0]       err_code;
    logic [DW-1:0]    depth;

    modport master (
        output tok_valid, tok_is_num, tok_op, tok_value,
        output alu_done, alu_err, alu_result,
        input  tok_ready, alu_start, alu_op, alu_a, alu_b,
        input  result_valid, result, error, err_code, depth
    );

    modport slave (
        input  tok_valid, tok_is_num, tok_op, tok_value,
        input  alu_done, alu_err, alu_result,
        output tok_ready, alu_start, alu_op, alu_a, alu_b,
        output result_valid, result, error, err_code, depth
    );

endinterface

// File: rtl/calc_operand_stack.sv
// Register-array LIFO holding calculator operands.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   i_push/i_push_data  write one entry on top (ignored when full)
//   i_pop2           drop the two top entries (ignored with fewer than two)
//   i_clear          empty the stack
//   o_top            entry at depth-1 (right operand)
//   o_second         entry at depth-2 (left operand)
//   o_depth          current occupancy, 0..DEPTH
//   o_full           occupancy equals DEPTH
module calc_operand_stack
    import calc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop2,
    input  logic                       i_clear,
    output logic [WIDTH-1:0]           o_top,
    output logic [WIDTH-1:0]           o_second,
    output logic [$clog2(DEPTH):0]     o_depth,
    output logic                       o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [DW-1:0]    r_depth;
    logic [WIDTH-1:0] w_mem [DEPTH];
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_second_idx;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop2;

    assign w_full       = (r_depth == DW'(DEPTH));
    assign w_do_push    = i_push && !w_full;
    assign w_do_pop2    = i_pop2 && (r_depth >= DW'(2));
    // Because DEPTH is a power of two, the low bits of depth address the
    // next free slot; the subtractions wrap harmlessly when the stack is
    // too shallow, and callers only use the read ports when it is not.
    assign w_wr_idx     = r_depth[AW-1:0];
    assign w_top_idx    = AW'(r_depth - DW'(1));
    assign w_second_idx = AW'(r_depth - DW'(2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_depth <= '0;
        end else if (i_clear) begin
            r_depth <= '0;
        end else if (w_do_push) begin
            r_depth <= r_depth + DW'(1);
        end else if (w_do_pop2) begin
            r_depth <= r_depth - DW'(2);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] r_entry;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_entry <= '0;
                end else if (i_clear) begin
                    r_entry <= '0;
                end else if (w_do_push && (w_wr_idx == AW'(gi))) begin
                    r_entry <= i_push_data;
                end
            end

            assign w_mem[gi] = r_entry;
        end
    endgenerate

    assign o_top    = w_mem[w_top_idx];
    assign o_second = w_mem[w_second_idx];
    assign o_depth  = r_depth;
    assign o_full   = w_full;

endmodule

// File: rtl/calc_sequencer.sv
// RPN execution controller for the stack calculator.
// Accepts number/operator tokens, keeps operands on calc_operand_stack,
// issues operand pairs to the external arithmetic unit and pushes the
// result back, then reports the final answer or an error.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    calc_sequencer_if.slave: token handshake, arithmetic-unit
//          request/response, result/error/depth reporting
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    calc_sequencer_if.slave  bus
);
    localparam int DW = $clog2(DEPTH) + 1;

    state_t           r_state,        w_state_next;
    logic             r_alu_start,    w_alu_start_next;
    logic [3:0]       r_alu_op,       w_alu_op_next;
    logic [WIDTH-1:0] r_alu_a,        w_alu_a_next;
    logic [WIDTH-1:0] r_alu_b,        w_alu_b_next;
    logic [WIDTH-1:0] r_capture,      w_capture_next;
    logic             r_result_valid, w_result_valid_next;
    logic [WIDTH-1:0] r_result,       w_result_next;
    logic             r_error,        w_error_next;
    logic [1:0]       r_err_code,     w_err_code_next;

    logic             w_tok_ready;
    logic             w_accept;
    logic             w_push;
    logic [WIDTH-1:0] w_push_data;
    logic             w_pop2;
    logic             w_clear;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_second;
    logic [DW-1:0]    w_depth;
    logic             w_full;

    calc_operand_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop2      (w_pop2),
        .i_clear     (w_clear),
        .o_top       (w_top),
        .o_second    (w_second),
        .o_depth     (w_depth),
        .o_full      (w_full)
    );

    assign w_tok_ready = (r_state == IDLE) || (r_state == DONE) || (r_state == ERROR);
    assign w_accept    = bus.tok_valid && w_tok_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_alu_start    <= 1'b0;
            r_alu_op       <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_capture      <= '0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_error        <= 1'b0;
            r_err_code     <= '0;
        end else begin
            r_state        <= w_state_next;
            r_alu_start    <= w_alu_start_next;
            r_alu_op       <= w_alu_op_next;
            r_alu_a        <= w_alu_a_next;
            r_alu_b        <= w_alu_b_next;
            r_capture      <= w_capture_next;
            r_result_valid <= w_result_valid_next;
            r_result       <= w_result_next;
            r_error        <= w_error_next;
            r_err_code     <= w_err_code_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_alu_start_next    = 1'b0;
        w_alu_op_next       = r_alu_op;
        w_alu_a_next        = r_alu_a;
        w_alu_b_next        = r_alu_b;
        w_capture_next      = r_capture;
        w_result_valid_next = r_result_valid;
        w_result_next       = r_result;
        w_error_next        = r_error;
        w_err_code_next     = r_err_code;
        w_push              = 1'b0;
        w_push_data         = bus.tok_value;
        w_pop2              = 1'b0;
        w_clear             = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.tok_is_num) begin
                        if (w_full) begin
                            w_state_next    = ERROR;
                            w_error_next    = 1'b1;
                            w_err_code_next = ERR_OVF;
                        end else begin
                            w_push = 1'b1;
                        end
                    end else if (is_arith_op(bus.tok_op)) begin
                        if (w_depth < DW'(2)) begin
                            w_state_next    = ERROR;
                            w_error_next    = 1'b1;
                            w_err_code_next = ERR_UNF;
                        end else begin
                            w_alu_a_next     = w_second;
                            w_alu_b_next     = w_top;
                            w_alu_op_next    = bus.tok_op;
                            w_alu_start_next = 1'b1;
                            w_pop2           = 1'b1;
                            w_state_next     = WAIT_ALU;
                        end
                    end else if (bus.tok_op == TOK_EQU) begin
                        if (w_depth == DW'(1)) begin
                            w_state_next        = DONE;
                            w_result_valid_next = 1'b1;
                            w_result_next       = w_top;
                        end else begin
                            w_state_next    = ERROR;
                            w_error_next    = 1'b1;
                            w_err_code_next = (w_depth == '0) ? ERR_UNF : ERR_MALFORMED;
                        end
                    end else if (bus.tok_op == TOK_CLR) begin
                        w_clear = 1'b1;
                    end
                    // Remaining operator codes are consumed without effect.
                end
            end

            WAIT_ALU: begin
                // A done coinciding with our own start pulse cannot belong to
                // this request, so only look once the pulse has dropped.
                if (!r_alu_start && bus.alu_done) begin
                    if (bus.alu_err) begin
                        w_state_next    = ERROR;
                        w_error_next    = 1'b1;
                        w_err_code_next = ERR_ALU;
                    end else begin
                        w_capture_next = bus.alu_result;
                        w_state_next   = PUSH;
                    end
                end
            end

            PUSH: begin
                // Two operands were just popped, so there is always room.
                w_push       = 1'b1;
                w_push_data  = r_capture;
                w_state_next = IDLE;
            end

            DONE, ERROR: begin
                // Only clear leaves these states; other tokens are swallowed.
                if (w_accept && !bus.tok_is_num && (bus.tok_op == TOK_CLR)) begin
                    w_clear             = 1'b1;
                    w_state_next        = IDLE;
                    w_result_valid_next = 1'b0;
                    w_result_next       = '0;
                    w_error_next        = 1'b0;
                    w_err_code_next     = ERR_MALFORMED;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.tok_ready    = w_tok_ready;
    assign bus.alu_start    = r_alu_start;
    assign bus.alu_op       = r_alu_op;
    assign bus.alu_a        = r_alu_a;
    assign bus.alu_b        = r_alu_b;
    assign bus.result_valid = r_result_valid;
    assign bus.result       = r_result;
    assign bus.error        = r_error;
    assign bus.err_code     = r_err_code;
    assign bus.depth        = w_depth;

endmodule
